// File: rtl/rv32_pkg.sv
// Shared RV32 core definitions: register index/word types and the MEM/WB
// writeback triple that feeds the architectural register file.
package rv32_pkg;

    localparam int NUM_WIDTH     = 5;
    localparam int OPERAND_WIDTH = 32;
    localparam int REG_ZERO      = 0;

    typedef logic [NUM_WIDTH-1:0]     reg_idx_t;
    typedef logic [OPERAND_WIDTH-1:0] word_t;

    // Writeback triple as registered by the MEM/WB stage
    typedef struct packed {
        logic     reg_write;
        reg_idx_t wr_num;
        word_t    wr_data;
    } wb_bus_t;

endpackage

// File: rtl/rv32_rf_read_port.sv
// One combinational register-file read port: forces x0 and reset to zero,
// and forwards the in-flight writeback data when it targets this index.
module rv32_rf_read_port
    import rv32_pkg::*;
#(
    parameter int num_width     = NUM_WIDTH,
    parameter int operand_width = OPERAND_WIDTH
) (
    input  logic                     rst_n,
    input  logic [num_width-1:0]     rd_num,
    input  logic                     wb_reg_write,
    input  logic [num_width-1:0]     wb_wr_num,
    input  logic [operand_width-1:0] wb_wr_data,
    input  logic [operand_width-1:0] stored_data,
    output logic [operand_width-1:0] rd_data
);

    logic is_zero_reg;
    logic bypass_hit;

    assign is_zero_reg = (rd_num == num_width'(REG_ZERO));
    assign bypass_hit  = wb_reg_write && (wb_wr_num == rd_num);

    // Select zero, the bypassed writeback value, or the stored entry
    always_comb begin
        rd_data = '0;
        if (!rst_n || is_zero_reg) begin
            rd_data = '0;
        end else if (bypass_hit) begin
            rd_data = wb_wr_data;
        end else begin
            rd_data = stored_data;
        end
    end

endmodule

// File: rtl/rv32_regfile_wb.sv
// RV32 architectural integer register file. Takes the MEM/WB writeback
// triple, serves two bypassed read ports to decode plus an unbypassed
// debug port, and counts committed non-x0 writes (saturating).
module rv32_regfile_wb
    import rv32_pkg::*;
#(
    parameter int num_width     = NUM_WIDTH,
    parameter int operand_width = OPERAND_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wb_reg_write,
    input  logic [num_width-1:0]     wb_wr_num,
    input  logic [operand_width-1:0] wb_wr_data,
    input  logic [num_width-1:0]     rs1_num,
    input  logic [num_width-1:0]     rs2_num,
    input  logic [num_width-1:0]     dbg_num,
    output logic [operand_width-1:0] rs1_data,
    output logic [operand_width-1:0] rs2_data,
    output logic [operand_width-1:0] dbg_data,
    output logic [15:0]              wr_count
);

    localparam int num_regs = 2 ** num_width;

    logic [operand_width-1:0] regs [num_regs];
    logic [15:0]              write_count;
    logic                     write_commit;

    // A write only commits for a non-x0 destination; x0 stays hardwired zero
    assign write_commit = wb_reg_write && (wb_wr_num != num_width'(REG_ZERO));

    // Storage update: synchronous clear on reset, otherwise commit the writeback
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < num_regs; i++) begin
                regs[i] <= '0;
            end
        end else if (write_commit) begin
            regs[wb_wr_num] <= wb_wr_data;
        end
    end

    // Committed-write counter, saturating at all-ones
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            write_count <= '0;
        end else if (write_commit && (write_count != 16'hFFFF)) begin
            write_count <= write_count + 16'd1;
        end
    end

    assign wr_count = write_count;

    rv32_rf_read_port #(
        .num_width     (num_width),
        .operand_width (operand_width)
    ) u_rs1_port (
        .rst_n         (rst_n),
        .rd_num        (rs1_num),
        .wb_reg_write  (wb_reg_write),
        .wb_wr_num     (wb_wr_num),
        .wb_wr_data    (wb_wr_data),
        .stored_data   (regs[rs1_num]),
        .rd_data       (rs1_data)
    );

    rv32_rf_read_port #(
        .num_width     (num_width),
        .operand_width (operand_width)
    ) u_rs2_port (
        .rst_n         (rst_n),
        .rd_num        (rs2_num),
        .wb_reg_write  (wb_reg_write),
        .wb_wr_num     (wb_wr_num),
        .wb_wr_data    (wb_wr_data),
        .stored_data   (regs[rs2_num]),
        .rd_data       (rs2_data)
    );

    // Debug read shows stored contents only, never the in-flight writeback
    always_comb begin
        dbg_data = '0;
        if (rst_n && (dbg_num != num_width'(REG_ZERO))) begin
            dbg_data = regs[dbg_num];
        end
    end

endmodule
